// File: rtl/mem_resp_sram_if.sv
// Request/response bundle for mem_resp_sram. Resp_Err exists only when
// MEM_RESP_SRAM_RANGE_ERR_EN is defined.
interface mem_resp_sram_if;
  logic        Read_Start;
  logic [63:0] Read_ADDR;
  logic [63:0] Read_Data;
  logic        Finish_Read;
  logic        Write_Start;
  logic [63:0] Write_ADDR;
  logic [63:0] Write_Data;
  logic [7:0]  Write_Strb;
  logic        Finish_Write;
`ifdef MEM_RESP_SRAM_RANGE_ERR_EN
  logic        Resp_Err;
`endif

  modport master (
    output Read_Start, Read_ADDR, Write_Start, Write_ADDR, Write_Data, Write_Strb,
    input  Read_Data, Finish_Read, Finish_Write
`ifdef MEM_RESP_SRAM_RANGE_ERR_EN
    , input Resp_Err
`endif
  );

  modport slave (
    input  Read_Start, Read_ADDR, Write_Start, Write_ADDR, Write_Data, Write_Strb,
    output Read_Data, Finish_Read, Finish_Write
`ifdef MEM_RESP_SRAM_RANGE_ERR_EN
    , output Resp_Err
`endif
  );
endinterface

// File: rtl/mem_resp_sram.sv
// Fixed-latency 64-bit SRAM responder with level-held Start / pulsed Finish.
// Optional range checking and Resp_Err output: MEM_RESP_SRAM_RANGE_ERR_EN.
module mem_resp_sram #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input logic            clk,
  input logic            rst,
  mem_resp_sram_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, REARM} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_is_wr, w_is_wr_nxt;
  logic        w_latch;
  logic        w_fire_rd, w_fire_wr;
  logic [63:0] r_addr, r_wdata;
  logic [7:0]  r_strb;
  logic [63:0] r_rdata;
  logic [63:0] r_mem [DEPTH];

  logic [63:0]      w_op_addr, w_op_data;
  logic [7:0]       w_op_strb;
  logic [63:0]      w_off;
  logic [IDX_W-1:0] w_idx;
  logic             w_oor;
  logic             w_fin_rd, w_fin_wr;
  logic [63:0]      w_rd_val;
  logic             w_wr_en;
  logic             w_unused;

  // The memory operation happens on the edge that raises Finish; with
  // LATENCY=1 that is the accepting edge itself, so operands come straight
  // from the bus while IDLE and from the latched copies otherwise.
  assign w_op_addr = (r_state == IDLE) ? (bus.Read_Start ? bus.Read_ADDR : bus.Write_ADDR) : r_addr;
  assign w_op_data = (r_state == IDLE) ? bus.Write_Data : r_wdata;
  assign w_op_strb = (r_state == IDLE) ? bus.Write_Strb : r_strb;
  assign w_off     = w_op_addr - BASE;
  assign w_idx     = w_off[IDX_W+2:3];
  assign w_oor     = |w_off[63:IDX_W+3];
  assign w_unused  = &{1'b0, w_off[2:0], w_oor};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_is_wr_nxt = r_is_wr;
    w_latch     = 1'b0;
    w_fire_rd   = 1'b0;
    w_fire_wr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Read_Start) begin
          w_state_nxt = RD_WAIT;
          w_cnt_nxt   = CNT_LOAD;
          w_is_wr_nxt = 1'b0;
          w_latch     = 1'b1;
          w_fire_rd   = (LATENCY == 1);
        end else if (bus.Write_Start) begin
          w_state_nxt = WR_WAIT;
          w_cnt_nxt   = CNT_LOAD;
          w_is_wr_nxt = 1'b1;
          w_latch     = 1'b1;
          w_fire_wr   = (LATENCY == 1);
        end
      end
      RD_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = REARM;
        end else if (!bus.Read_Start) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          w_fire_rd = (r_cnt == 4'd1);
        end
      end
      WR_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = REARM;
        end else if (!bus.Write_Start) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          w_fire_wr = (r_cnt == 4'd1);
        end
      end
      REARM: begin
        if (r_is_wr ? !bus.Write_Start : !bus.Read_Start) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_is_wr <= w_is_wr_nxt;
      if (w_latch) begin
        r_addr  <= w_op_addr;
        r_wdata <= bus.Write_Data;
        r_strb  <= bus.Write_Strb;
      end
    end
  end

`ifdef MEM_RESP_SRAM_RANGE_ERR_EN
  logic r_err;

  assign w_rd_val = w_oor ? '0 : r_mem[w_idx];
  assign w_wr_en  = w_fire_wr & ~w_oor & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_err <= 1'b0;
    else if (w_fire_rd | w_fire_wr) r_err <= w_oor;
  end

  assign bus.Resp_Err = r_err & (w_fin_rd | w_fin_wr);
`else
  assign w_rd_val = r_mem[w_idx];
  assign w_wr_en  = w_fire_wr & ~rst;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_rdata <= '0;
    else if (w_fire_rd) r_rdata <= w_rd_val;
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (w_op_strb[i]) r_mem[w_idx][8*i +: 8] <= w_op_data[8*i +: 8];
      end
    end
  end

  assign w_fin_rd         = (r_state == RD_WAIT) && (r_cnt == '0);
  assign w_fin_wr         = (r_state == WR_WAIT) && (r_cnt == '0);
  assign bus.Finish_Read  = w_fin_rd;
  assign bus.Finish_Write = w_fin_wr;
  assign bus.Read_Data    = r_rdata;

endmodule

// File: tb/tb_mem_resp_sram.sv
// Self-checking bench for mem_resp_sram: word-level memory model plus
// per-cycle compare of Finish_Read/Finish_Write/Read_Data (and Resp_Err).
module tb_mem_resp_sram;

  localparam int unsigned DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h8000_0000;
`ifdef MEM_RESP_SRAM_RANGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  mem_resp_sram_if bus();

  mem_resp_sram #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Model state
  logic [63:0] m_mem [int unsigned];
  logic [63:0] m_rdata = '0;
  int          m_rd_edge = -1;
  int          m_wr_edge = -1;
  logic [63:0] m_rd_addr, m_wr_addr, m_wr_data;
  logic [7:0]  m_wr_strb;
  int          last_fr_cyc = -1;
  int          last_fw_cyc = -1;
  int          n_fr = 0;
  int          n_fw = 0;

  function automatic int unsigned f_idx(logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return int'((off >> 3) % 64'(DEPTH));
  endfunction

  function automatic bit f_oor(logic [63:0] a);
    return (a - BASE) >= 64'(8 * DEPTH);
  endfunction

  function automatic logic [63:0] mem_get(int unsigned i);
    return m_mem.exists(i) ? m_mem[i] : 64'hx;
  endfunction

  task automatic mem_put(int unsigned i, logic [63:0] d, logic [7:0] s);
    logic [63:0] w;
    w = mem_get(i);
    for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    m_mem[i] = w;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic efr, efw, eerr;
    efr = 1'b0; efw = 1'b0; eerr = 1'b0;
    if (rst) begin
      m_rdata   = '0;
      m_rd_edge = -1;
      m_wr_edge = -1;
    end else begin
      if (cyc == m_rd_edge) begin
        efr = 1'b1;
        if (ERR_EN && f_oor(m_rd_addr)) begin
          m_rdata = '0;
          eerr    = 1'b1;
        end else begin
          m_rdata = mem_get(f_idx(m_rd_addr));
        end
      end
      if (cyc == m_wr_edge) begin
        efw = 1'b1;
        if (ERR_EN && f_oor(m_wr_addr)) eerr = 1'b1;
        else mem_put(f_idx(m_wr_addr), m_wr_data, m_wr_strb);
      end
    end
    chk("Finish_Read", 64'(bus.Finish_Read), 64'(efr));
    chk("Finish_Write", 64'(bus.Finish_Write), 64'(efw));
    chk("Read_Data", bus.Read_Data, m_rdata);
`ifdef MEM_RESP_SRAM_RANGE_ERR_EN
    chk("Resp_Err", 64'(bus.Resp_Err), 64'(eerr));
`endif
    if (bus.Finish_Read === 1'b1) begin last_fr_cyc = cyc; n_fr++; end
    if (bus.Finish_Write === 1'b1) begin last_fw_cyc = cyc; n_fw++; end
  end

  // Raise Start, scramble operands while waiting, hold 'hold' cycles past
  // the expected Finish, drop Start, then idle 'idle' extra cycles.
  task automatic do_req(input bit rd, input logic [63:0] addr, input logic [63:0] data,
                        input logic [7:0] strb, input int hold, input int idle, output int c);
    @(negedge clk); #2;
    c = cyc;
    if (rd) begin
      bus.Read_ADDR  = addr;
      bus.Read_Start = 1'b1;
      m_rd_addr      = addr;
      m_rd_edge      = c + LAT;
    end else begin
      bus.Write_ADDR  = addr;
      bus.Write_Data  = data;
      bus.Write_Strb  = strb;
      bus.Write_Start = 1'b1;
      m_wr_addr       = addr;
      m_wr_data       = data;
      m_wr_strb       = strb;
      m_wr_edge       = c + LAT;
    end
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk); #2;
      bus.Read_ADDR  = ~addr;
      bus.Write_ADDR = ~addr;
      bus.Write_Data = ~data;
      bus.Write_Strb = ~strb;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #2;
    end
    if (rd) bus.Read_Start = 1'b0;
    else    bus.Write_Start = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic rd(input logic [63:0] addr, output int c);
    do_req(1'b1, addr, '0, '0, 0, 1, c);
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb, output int c);
    do_req(1'b0, addr, data, strb, 0, 1, c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int nr, nw;
    rst             = 1'b1;
    bus.Read_Start  = 1'b0;
    bus.Write_Start = 1'b0;
    bus.Read_ADDR   = '0;
    bus.Write_ADDR  = '0;
    bus.Write_Data  = '0;
    bus.Write_Strb  = '0;
    repeat (3) @(negedge clk);
    chk("reset Read_Data", bus.Read_Data, 64'h0);
    #2 rst = 1'b0;

    // Basic write/read with latency pins
    wr(64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, c);
    chk("write latency", 64'(last_fw_cyc - c), 64'd2);
    rd(64'h8000_0008, c);
    chk("read latency", 64'(last_fr_cyc - c), 64'd2);
    chk("read word1", bus.Read_Data, 64'h1122_3344_5566_7788);

    // Partial strobe, then empty strobe
    wr(64'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, c);
    rd(64'h8000_0008, c);
    chk("strb 0F merge", bus.Read_Data, 64'h1122_3344_BBBB_BBBB);
    wr(64'h8000_000F, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, c);
    chk("strb 0 completes", 64'(last_fw_cyc - c), 64'd2);
    rd(64'h8000_0008, c);
    chk("strb 0 no change", bus.Read_Data, 64'h1122_3344_BBBB_BBBB);

    // Wrap above the array
    wr(64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, c);
    wr(64'h8000_2010, 64'hCAFE_BABE_DEAD_BEEF, 8'hFF, c);
    rd(64'h8000_0010, c);
    chk("wrap high", bus.Read_Data, ERR_EN ? 64'h0123_4567_89AB_CDEF : 64'hCAFE_BABE_DEAD_BEEF);

    // Below BASE -> index DEPTH-1 (or error)
    wr(64'h8000_1FF8, 64'h5A5A_0000_FFFF_1234, 8'hFF, c);
    rd(64'h7FFF_FFF8, c);
    chk("wrap low", bus.Read_Data, ERR_EN ? 64'h0 : 64'h5A5A_0000_FFFF_1234);

    // Read and write raised together: read first, write after REARM
    nr = n_fr; nw = n_fw;
    @(negedge clk); #2;
    c = cyc;
    bus.Read_ADDR   = 64'h8000_0008;
    bus.Write_ADDR  = 64'h8000_0028;
    bus.Write_Data  = 64'h0F0E_0D0C_0B0A_0908;
    bus.Write_Strb  = 8'hFF;
    bus.Read_Start  = 1'b1;
    bus.Write_Start = 1'b1;
    m_rd_addr = 64'h8000_0008; m_rd_edge = c + 2;
    m_wr_addr = 64'h8000_0028; m_wr_data = 64'h0F0E_0D0C_0B0A_0908; m_wr_strb = 8'hFF;
    m_wr_edge = c + 6;
    repeat (2) @(negedge clk);
    #2 bus.Read_Start = 1'b0;
    repeat (4) @(negedge clk);
    #2 bus.Write_Start = 1'b0;
    @(negedge clk);
    chk("dual read edge", 64'(last_fr_cyc - c), 64'd2);
    chk("dual write edge", 64'(last_fw_cyc - c), 64'd6);
    chk("dual one read", 64'(n_fr - nr), 64'd1);
    chk("dual one write", 64'(n_fw - nw), 64'd1);
    rd(64'h8000_0028, c);
    chk("dual write data", bus.Read_Data, 64'h0F0E_0D0C_0B0A_0908);

    // Held Start: one completion only, then re-accept after one low cycle
    nr = n_fr;
    do_req(1'b1, 64'h8000_0008, '0, '0, 10, 0, c);
    chk("held single pulse", 64'(n_fr - nr), 64'd1);
    rd(64'h8000_0028, c);
    chk("rearm reaccept", 64'(last_fr_cyc - c), 64'd2);

    // Aborts: Start dropped inside WAIT
    @(negedge clk); #2;
    bus.Write_ADDR = 64'h8000_0008; bus.Write_Data = '0; bus.Write_Strb = 8'hFF;
    bus.Write_Start = 1'b1;
    @(negedge clk); #2;
    bus.Write_Start = 1'b0;
    @(negedge clk); #2;
    bus.Read_ADDR = 64'h8000_0010;
    bus.Read_Start = 1'b1;
    @(negedge clk); #2;
    bus.Read_Start = 1'b0;
    @(negedge clk);
    chk("abort keeps Read_Data", bus.Read_Data, 64'h0F0E_0D0C_0B0A_0908);
    rd(64'h8000_0008, c);
    chk("abort no write", bus.Read_Data, 64'h1122_3344_BBBB_BBBB);

    // Reset one cycle into WR_WAIT
    @(negedge clk); #2;
    bus.Write_ADDR = 64'h8000_0008; bus.Write_Data = 64'hDEAD_0000_DEAD_0000; bus.Write_Strb = 8'hFF;
    bus.Write_Start = 1'b1;
    @(negedge clk); #2;
    rst = 1'b1;
    bus.Write_Start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst Read_Data", bus.Read_Data, 64'h0);
    chk("rst Finish_Write", 64'(bus.Finish_Write), 64'd0);
    #2 rst = 1'b0;
    rd(64'h8000_0008, c);
    chk("rst no write", bus.Read_Data, 64'h1122_3344_BBBB_BBBB);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_resp_sram.md
MEM_RESP_SRAM -- requirements
Module: mem_resp_sram

Interface
REQ-001 Parameter DEPTH, default 1024, number of 64-bit words in the backing array; power of two.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to Finish pulse; legal range 1..15.
REQ-003 Parameter BASE, default 64'h8000_0000, byte address of word 0.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 Read_Start  input  1  read request level; the initiator holds it high until it sees Finish_Read.
REQ-007 Read_ADDR  input  64  read byte address; bits [2:0] ignored.
REQ-008 Read_Data  output  64  registered read data.
REQ-009 Finish_Read  output  1  one-cycle read completion pulse.
REQ-010 Write_Start  input  1  write request level; the initiator holds it high until it sees Finish_Write.
REQ-011 Write_ADDR  input  64  write byte address; bits [2:0] ignored.
REQ-012 Write_Data  input  64  write data, byte lanes aligned to the address.
REQ-013 Write_Strb  input  8  byte enables; bit i enables Write_Data[8i+7:8i].
REQ-014 Finish_Write  output  1  one-cycle write completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, RD_WAIT, WR_WAIT and REARM.
- IDLE -> RD_WAIT when Read_Start=1.
- IDLE -> WR_WAIT when Write_Start=1 and Read_Start=0.
REQ-016 If Read_Start and Write_Start are both high in IDLE, the read SHALL be served first; the write SHALL be served after REARM because Write_Start is still held.
REQ-017 On entry to a WAIT state, the block SHALL latch address, data and strobes and load the latency counter with LATENCY-1; later input changes SHALL be ignored.
REQ-018 If a request is sampled at edge k, Finish SHALL be high for exactly the cycle following edge k+LATENCY-1; LATENCY=1 gives Finish in the cycle after edge k.
REQ-019 A read SHALL update Read_Data at the same edge that raises Finish_Read; Read_Data SHALL hold that value until the next read completes.
REQ-020 A write SHALL update only the strobed bytes of word index (addr-BASE)>>3 at the same edge that raises Finish_Write; Write_Strb=0 SHALL still complete with no memory change.
REQ-021 The address index SHALL be (addr-BASE)>>3 taken modulo DEPTH, so out-of-range addresses wrap.
REQ-022 After Finish, the FSM SHALL go to REARM and stay there until the corresponding Start is low, then return to IDLE; a held Start SHALL never produce a second completion.
REQ-023 If Start drops during a WAIT state, the FSM SHALL abort to IDLE with no Finish pulse, no memory write and no Read_Data change.
REQ-024 A read of a word written by a completed write SHALL return the new data; there SHALL be no stale forwarding window.

Reset
REQ-025 While rst=1: state=IDLE, counter=0, Finish_Read=0, Finish_Write=0, Read_Data=64'h0; array contents SHALL NOT be reset.
REQ-026 Reset asserted mid-request SHALL abort the request with no Finish pulse and no array write.

Configuration
REQ-027 Macro MEM_RESP_SRAM_RANGE_ERR_EN SHALL add output Resp_Err (1 bit, reset 0).
- Defined: Resp_Err pulses together with Finish when the address is outside [BASE, BASE+8*DEPTH); a faulting read returns Read_Data=64'h0 and a faulting write leaves the array unchanged.
- Undefined: no Resp_Err port; out-of-range addresses wrap per REQ-021.

Verification
REQ-028 LATENCY=2, write 0x8000_0008 data 0x1122334455667788 strb 0xFF, then read 0x8000_0008 -> each Finish exactly 2 cycles after Start is sampled, Read_Data=0x1122334455667788.
REQ-029 Write strb 0x0F data 0xAAAAAAAA_BBBBBBBB over a word holding 0x1122334455667788 -> a read returns 0x11223344_BBBBBBBB.
REQ-030 Read_Start and Write_Start rise together and both stay held -> Finish_Read first, REARM, then Finish_Write; exactly one pulse each.
REQ-031 Read_Start is held high for 10 cycles after Finish_Read -> no second Finish_Read; a new read is accepted one cycle after Start goes low and then high again.
REQ-032 rst is asserted one cycle into WR_WAIT -> no Finish_Write, the word is unchanged on a later read, and outputs are 0 during reset.
REQ-033 With MEM_RESP_SRAM_RANGE_ERR_EN, a read of 0x7FFF_FFF8 -> Finish_Read plus Resp_Err, Read_Data=0; without it, the same read returns the word at index DEPTH-1.
